// File: rtl/key_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// key_cond_pkg
// Shared definitions for the key conditioner: the lane count, the lane FSM
// state type, the default timing parameters, the counter widths and the
// saturating increment helpers used by the lane counters.
//
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat, see key_lane).
// -----------------------------------------------------------------------------
package key_cond_pkg;

    localparam int unsigned NUM_LANES = 4;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_REPEAT_DELAY    = 64;
    localparam int unsigned DEF_REPEAT_PERIOD   = 16;

    localparam int unsigned DB_CNT_W  = 8;
    localparam int unsigned RPT_CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } lane_state_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [DB_CNT_W-1:0] db_sat_inc(input logic [DB_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [RPT_CNT_W-1:0] rpt_sat_inc(input logic [RPT_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/key_conditioner_lane.sv
// -----------------------------------------------------------------------------
// key_lane
// One key lane: 2-flop synchronizer, debounce FSM (IDLE, PRESS_WAIT, HELD,
// RELEASE_WAIT) with an 8-bit saturating debounce counter and, when
// KEY_AUTOREPEAT_EN is defined, a 10-bit saturating auto-repeat counter.
//
// Ports:
//   clk_i        rising-edge clock
//   reset_n_i    asynchronous active-low reset
//   key_n_i      raw active-low key, asynchronous to clk_i
//   press_o      registered one-cycle pulse per accepted press (and repeats)
//   release_o    registered one-cycle pulse per accepted release
//   held_o       registered debounced level, high while accepted as pressed
//   press_next_o next-cycle value of press_o, lets the top register an OR
//                of all lanes that lines up with press_o
//
// Optional feature macro: KEY_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module key_lane
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic key_n_i,
    output logic press_o,
    output logic release_o,
    output logic held_o,
    output logic press_next_o
);

    localparam logic [DB_CNT_W-1:0] DB_TARGET = DEBOUNCE_CYCLES[DB_CNT_W-1:0];

    logic                sync1_q;
    logic                sync2_q;
    lane_state_t         state_q;
    lane_state_t         state_d;
    logic [DB_CNT_W-1:0] db_cnt_q;
    logic [DB_CNT_W-1:0] db_cnt_d;
    logic                press_q;
    logic                press_d;
    logic                release_q;
    logic                release_d;
    logic                held_q;
    logic                held_d;
    logic                key_low;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [RPT_CNT_W-1:0] RPT_DELAY_T  = REPEAT_DELAY[RPT_CNT_W-1:0];
    localparam logic [RPT_CNT_W-1:0] RPT_PERIOD_T = REPEAT_PERIOD[RPT_CNT_W-1:0];

    // rpt_cnt counts HELD cycles since the last press pulse; rpt_first
    // selects the initial delay until the first repeat has fired.
    logic [RPT_CNT_W-1:0] rpt_cnt_q;
    logic [RPT_CNT_W-1:0] rpt_cnt_d;
    logic                 rpt_first_q;
    logic                 rpt_first_d;
    logic [RPT_CNT_W-1:0] rpt_inc;
    logic [RPT_CNT_W-1:0] rpt_target;

    assign rpt_inc    = rpt_sat_inc(rpt_cnt_q);
    assign rpt_target = rpt_first_q ? RPT_DELAY_T : RPT_PERIOD_T;
`else
    // Repeat timing has no effect in this build.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY[RPT_CNT_W-1:0], REPEAT_PERIOD[RPT_CNT_W-1:0]};
`endif

    assign key_low = ~sync2_q;

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        held_d    = held_q;
`ifdef KEY_AUTOREPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
`endif
        case (state_q)
            IDLE: begin
                if (key_low) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = {{(DB_CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    db_cnt_d = '0;
                end
            end

            PRESS_WAIT: begin
                if (!key_low) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_TARGET) begin
                    state_d  = HELD;
                    db_cnt_d = '0;
                    press_d  = 1'b1;
                    held_d   = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
`endif
                end else begin
                    db_cnt_d = db_sat_inc(db_cnt_q);
                end
            end

            HELD: begin
                if (!key_low) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = {{(DB_CNT_W-1){1'b0}}, 1'b1};
                end else begin
`ifdef KEY_AUTOREPEAT_EN
                    if (rpt_inc >= rpt_target) begin
                        press_d     = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_first_d = 1'b0;
                    end else begin
                        rpt_cnt_d = rpt_inc;
                    end
`endif
                end
            end

            RELEASE_WAIT: begin
                // Repeat counter is left untouched here so it resumes on a
                // bounce back to HELD.
                if (key_low) begin
                    state_d  = HELD;
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_TARGET) begin
                    state_d   = IDLE;
                    db_cnt_d  = '0;
                    release_d = 1'b1;
                    held_d    = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_first_d = 1'b1;
`endif
                end else begin
                    db_cnt_d = db_sat_inc(db_cnt_q);
                end
            end

            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
                held_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            db_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            sync1_q   <= key_n_i;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            held_q    <= held_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    assign press_o      = press_q;
    assign release_o    = release_q;
    assign held_o       = held_q;
    assign press_next_o = press_d;

endmodule

// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
// Debounces NUM_LANES raw active-low keys into press/release pulses and a
// held level per lane, plus a combined any_press pulse.
//
// Ports:
//   clk_i        rising-edge clock (shared with the gameplay stage)
//   reset_n_i    asynchronous active-low reset
//   key_n_i      raw active-low keys, bit 3 is the leftmost lane
//   press_o      per-lane one-cycle press pulse (plus repeats when enabled)
//   release_o    per-lane one-cycle release pulse
//   held_o       per-lane debounced level
//   any_press_o  OR of press_o, registered so it is high in the same cycle
//
// Optional feature macro: KEY_AUTOREPEAT_EN (per-lane auto-repeat).
// -----------------------------------------------------------------------------
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [NUM_LANES-1:0] key_n_i,
    output logic [NUM_LANES-1:0] press_o,
    output logic [NUM_LANES-1:0] release_o,
    output logic [NUM_LANES-1:0] held_o,
    output logic                 any_press_o
);

    logic [NUM_LANES-1:0] press_next;
    logic                 any_press_q;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        key_lane #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_lane (
            .clk_i        (clk_i),
            .reset_n_i    (reset_n_i),
            .key_n_i      (key_n_i[g]),
            .press_o      (press_o[g]),
            .release_o    (release_o[g]),
            .held_o       (held_o[g]),
            .press_next_o (press_next[g])
        );
    end

    // Registered from the lanes' next-cycle press values so it lines up
    // with press_o rather than trailing it by a cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_next;
        end
    end

    assign any_press_o = any_press_q;

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 4;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_n;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] held;
    logic       any_press;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    key_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .key_n_i     (key_n),
        .press_o     (press),
        .release_o   (rel),
        .held_o      (held),
        .any_press_o (any_press)
    );

    // Reference model: the key level seen two edges late is compared with the
    // accepted level; DB+1 consecutive differing samples flip the accepted
    // level. Repeats count cycles spent pressed with no pending change.
    bit         m_acc [4];
    int         m_run [4];
    int         m_el  [4];
    bit         m_first [4];
    logic [3:0] m_d1, m_d2, m_samp;
    logic [3:0] m_press, m_rel, m_held;
    logic       m_any;
    int         m_tgt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l < 4; l++) begin
                m_acc[l] = 1'b0; m_run[l] = 0; m_el[l] = 0; m_first[l] = 1'b1;
            end
            m_d1 = '1; m_d2 = '1;
            m_press = '0; m_rel = '0; m_held = '0; m_any = 1'b0;
        end else begin
            m_samp = m_d2; m_d2 = m_d1; m_d1 = key_n;
            m_press = '0; m_rel = '0;
            for (int l = 0; l < 4; l++) begin
                if ((m_samp[l] == 1'b0) != m_acc[l]) begin
                    m_run[l]++;
                    if (m_run[l] == DB + 1) begin
                        m_acc[l] = !m_acc[l];
                        m_run[l] = 0; m_el[l] = 0; m_first[l] = 1'b1;
                        if (m_acc[l]) m_press[l] = 1'b1;
                        else          m_rel[l]   = 1'b1;
                    end
                end else begin
                    if (AR && m_acc[l] && m_run[l] == 0) begin
                        m_el[l]++;
                        m_tgt = m_first[l] ? RD : RP;
                        if (m_el[l] == m_tgt) begin
                            m_press[l] = 1'b1; m_el[l] = 0; m_first[l] = 1'b0;
                        end
                    end
                    m_run[l] = 0;
                end
                m_held[l] = m_acc[l];
            end
            m_any = |m_press;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_n   = '1;
        for (int e = 0; e < 4; e++) begin
            step();
            total++;
            if ({press, rel, held, any_press} !== 13'b0) begin
                bad++;
                $display("FAIL reset_outputs e=%0d got p=%b r=%b h=%b a=%b exp all 0", e, press, rel, held, any_press);
            end
        end
        reset_n = 1'b1;
        for (int e = 0; e < 3; e++) step();
    endtask

    task automatic test_press();
        key_n = 4'b0111;
        for (int e = 0; e < 20; e++) begin
            step();
            total++;
            if ({press, rel, held, any_press} !== {m_press, m_rel, m_held, m_any}) begin
                bad++;
                $display("FAIL press_model e=%0d got p=%b r=%b h=%b a=%b exp p=%b r=%b h=%b a=%b", e, press, rel, held, any_press, m_press, m_rel, m_held, m_any);
            end
            total++;
            if (press[3] !== (e == 6 || (AR && (e == 14 || e == 18)))) begin
                bad++;
                $display("FAIL press_pulse e=%0d got %b", e, press[3]);
            end
            total++;
            if (held[3] !== (e >= 6)) begin
                bad++;
                $display("FAIL press_held e=%0d got %b exp %b", e, held[3], e >= 6);
            end
        end
        key_n = '1;
        for (int e = 0; e < 10; e++) begin
            step();
            total++;
            if (rel[3] !== (e == 6) || held[3] !== (e < 6) || press[3] !== 1'b0) begin
                bad++;
                $display("FAIL release_lane3 e=%0d got r=%b h=%b p=%b exp r=%b h=%b p=0", e, rel[3], held[3], press[3], e == 6, e < 6);
            end
        end
    endtask

    task automatic test_bounce();
        bit low_seq [7] = '{1, 1, 1, 0, 1, 1, 1};
        for (int e = 0; e < 16; e++) begin
            key_n = 4'b1111;
            if (e < 7) key_n[1] = !low_seq[e];
            step();
            total++;
            if ({press[1], rel[1], held[1]} !== 3'b000) begin
                bad++;
                $display("FAIL bounce_lane1 e=%0d got p=%b r=%b h=%b exp 000", e, press[1], rel[1], held[1]);
            end
            total++;
            if ({press, rel, held, any_press} !== {m_press, m_rel, m_held, m_any}) begin
                bad++;
                $display("FAIL bounce_model e=%0d got p=%b r=%b h=%b exp p=%b r=%b h=%b", e, press, rel, held, m_press, m_rel, m_held);
            end
        end
    endtask

    task automatic test_simultaneous();
        key_n = 4'b0000;
        for (int e = 0; e < 10; e++) begin
            step();
            total++;
            if (press !== ((e == 6) ? 4'hF : 4'h0) || any_press !== (e == 6) ||
                held !== ((e >= 6) ? 4'hF : 4'h0)) begin
                bad++;
                $display("FAIL simul_press e=%0d got p=%b a=%b h=%b", e, press, any_press, held);
            end
        end
        key_n = 4'b1111;
        for (int e = 0; e < 10; e++) begin
            step();
            total++;
            if (rel !== ((e == 6) ? 4'hF : 4'h0) || press !== 4'h0 ||
                held !== ((e < 6) ? 4'hF : 4'h0)) begin
                bad++;
                $display("FAIL simul_release e=%0d got r=%b p=%b h=%b", e, rel, press, held);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        int pulses = 0;
        key_n = 4'b1110;
        for (int e = 0; e < 8; e++) step();
        total++;
        if (held[0] !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre_held got %b exp 1", held[0]);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({press, rel, held, any_press} !== 13'b0) begin
            bad++;
            $display("FAIL rst_immediate got p=%b r=%b h=%b a=%b exp all 0", press, rel, held, any_press);
        end
        for (int e = 0; e < 3; e++) begin
            step();
            total++;
            if ({press, rel, held, any_press} !== 13'b0) begin
                bad++;
                $display("FAIL rst_hold e=%0d got p=%b r=%b h=%b a=%b exp all 0", e, press, rel, held, any_press);
            end
        end
        reset_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            if (press[0]) pulses++;
            total++;
            if (press[0] !== (e == 6) || rel[0] !== 1'b0) begin
                bad++;
                $display("FAIL rst_repress e=%0d got p=%b r=%b exp p=%b r=0", e, press[0], rel[0], e == 6);
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL rst_repress_count got %0d exp 1", pulses);
        end
        key_n = '1;
        for (int e = 0; e < 10; e++) begin
            step();
            total++;
            if ({press, rel, held, any_press} !== {m_press, m_rel, m_held, m_any}) begin
                bad++;
                $display("FAIL rst_model e=%0d got p=%b r=%b h=%b exp p=%b r=%b h=%b", e, press, rel, held, m_press, m_rel, m_held);
            end
        end
    endtask

    task automatic test_autorepeat();
        bit exp_p;
        for (int e = 0; e < 42; e++) begin
            key_n = (e < 30) ? 4'b1011 : 4'b1111;
            step();
            exp_p = (e == 6) || (AR && (e == 14 || e == 18 || e == 22 || e == 26 || e == 30));
            total++;
            if (press[2] !== exp_p || any_press !== exp_p) begin
                bad++;
                $display("FAIL autorepeat e=%0d got p=%b a=%b exp %b", e, press[2], any_press, exp_p);
            end
            total++;
            if ({press, rel, held, any_press} !== {m_press, m_rel, m_held, m_any}) begin
                bad++;
                $display("FAIL autorepeat_model e=%0d got p=%b r=%b h=%b exp p=%b r=%b h=%b", e, press, rel, held, m_press, m_rel, m_held);
            end
        end
    endtask

    task automatic test_random();
        key_n = '1;
        for (int e = 0; e < 3000; e++) begin
            for (int l = 0; l < 4; l++)
                if ($urandom_range(0, 9) == 0) key_n[l] = ~key_n[l];
            step();
            total++;
            if ({press, rel, held, any_press} !== {m_press, m_rel, m_held, m_any}) begin
                bad++;
                $display("FAIL random_model e=%0d got p=%b r=%b h=%b a=%b exp p=%b r=%b h=%b a=%b", e, press, rel, held, any_press, m_press, m_rel, m_held, m_any);
            end
            total++;
            if ((press & rel) !== 4'b0) begin
                bad++;
                $display("FAIL random_exclusive e=%0d got p=%b r=%b", e, press, rel);
            end
        end
        key_n = '1;
        for (int e = 0; e < 12; e++) step();
    endtask

    initial begin
        reset_n = 1'b0;
        key_n   = '1;
        test_reset();
        test_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_press();
        test_autorepeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized samples required to accept a press or release; legal range 1..255.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 64, cycles from a press pulse to the first auto-repeat pulse; legal range 1..1023.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 16, cycles between later auto-repeat pulses; legal range 1..1023.
REQ-004 clk  input  1  single clock, shared with the gameplay stage; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 key_n  input  4  raw board keys, active-low, asynchronous; bit 3 is the leftmost lane.
REQ-007 press  output  4  one-cycle active-high pulse per accepted press (plus repeats when enabled).
REQ-008 release  output  4  one-cycle active-high pulse per accepted release.
REQ-009 held  output  4  debounced level, high while the lane is accepted as pressed.
REQ-010 any_press  output  1  OR of press, registered in the same cycle as press.

Function
REQ-011 Each key_n bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each lane SHALL run an independent FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT.
REQ-013 IDLE -> PRESS_WAIT on a synchronized-low sample, with the counter loaded to 1.
REQ-014 PRESS_WAIT SHALL increment on each low sample; at count == DEBOUNCE_CYCLES it SHALL go to HELD, pulse press and set held.
REQ-015 PRESS_WAIT SHALL return to IDLE with the counter cleared on any high sample (bounce), with no pulse.
REQ-016 HELD -> RELEASE_WAIT on a synchronized-high sample; RELEASE_WAIT SHALL mirror PRESS_WAIT.
REQ-017 RELEASE_WAIT completion SHALL go to IDLE, pulse release and clear held; a low sample SHALL return to HELD with no pulse and held still high.
REQ-018 Latency: a key_n low held stable from edge 0 SHALL give press high after edge DEBOUNCE_CYCLES+2; release SHALL have the same latency.
REQ-019 With DEBOUNCE_CYCLES = 1, press SHALL assert after edge 3.
REQ-020 press and release of one lane SHALL never be high in the same cycle.
REQ-021 Lanes SHALL be fully independent; simultaneous events on any lanes SHALL pulse in the same cycle.
REQ-022 Debounce counters SHALL be 8 bits; repeat counters SHALL be 10 bits; counters SHALL saturate and never wrap.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 While reset_n is low: all FSMs SHALL be IDLE; counters 0; synchronizer flops 1 (released); press, release, held and any_press all 0.
REQ-025 Reset asserted mid-press SHALL abort it with no release pulse.
REQ-026 A key still low after reset deassertion SHALL be treated as a new press (full debounce, then one press pulse).

Configuration
REQ-027 With macro KEY_AUTOREPEAT_EN defined, a lane in HELD SHALL pulse press REPEAT_DELAY cycles after its press pulse, then every REPEAT_PERIOD cycles while it stays in HELD.
REQ-028 The repeat counter SHALL pause in RELEASE_WAIT, resume if the lane returns to HELD, and clear on entering IDLE.
REQ-029 With KEY_AUTOREPEAT_EN undefined, exactly one press pulse SHALL occur per accepted press, and no repeat counters SHALL be synthesized.

Structure
REQ-030 Package key_cond_pkg SHALL hold the lane_state_t enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), the lane count constant NUM_LANES = 4, and the default parameter values.
REQ-031 Sub-module key_lane SHALL implement the synchronizer, FSM and counters for one lane; it SHALL be instantiated NUM_LANES times in a generate loop.
REQ-032 The top level SHALL only instantiate the lanes and form any_press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4)
REQ-033 Press test: key_n[3] low at edge 0 for 20 cycles -> press[3] one pulse after edge 6, held[3] high from edge 6; key_n[3] high -> release[3] pulse 6 edges later, held[3] low.
REQ-034 Bounce test: key_n[1] low 3 cycles, high 1, low 3, then high -> no press, held or release activity on lane 1.
REQ-035 Simultaneous test: key_n = 4'b0000 at one edge -> press = 4'b1111 for exactly one cycle, any_press high in that cycle, held = 4'b1111.
REQ-036 Reset test: reset_n low while lane 0 is HELD -> all outputs 0 immediately, no release pulse; after reset_n high with key still low, one new press pulse after 6 edges.
REQ-037 Auto-repeat test (KEY_AUTOREPEAT_EN): key_n[2] held 30 cycles -> press[2] pulses after edges 6, 14, 18, 22, 26, 30; the same bench without the macro -> only the edge-6 pulse.
